// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - single-master, N-slave memory-mapped bus fabric
//
// Decodes the master address against per-slave base/mask windows, registers
// the request, drives exactly one slave through a one-hot enable and returns
// a registered one-cycle completion. Unmapped accesses and slaves that never
// answer complete with an error so the master cannot hang.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   m_addr        master address
//   m_wdata       master write data
//   m_wstrb       master byte enables
//   m_write       1 = write, 0 = read
//   m_enable      request valid, held stable until m_ready
//   m_rdata       completion read data (valid while m_ready)
//   m_ready       one-cycle completion pulse
//   m_error       completion is an error (valid while m_ready)
//   s_addr        latched address, broadcast to all slaves
//   s_wdata       latched write data, broadcast
//   s_wstrb       latched byte enables, broadcast
//   s_write       latched direction, broadcast
//   s_enable      one-hot slave select, high for the cycles spent in ACTIVE
//   s_rdata       flattened slave read data, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_ready       per-slave done, may be combinational from s_enable
//   err_count     saturating count of error completions
//
// ERR_COUNT_WIDTH sets the width of the internal error counter; it saturates
// at all-ones of that width and is zero-extended onto the 16-bit err_count.

module bus_fabric #(
  parameter int NUM_SLAVES      = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h4000_2000, 32'h4000_1000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hC000_0000},
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic [DATA_WIDTH/8-1:0]          m_wstrb,
  input  logic                             m_write,
  input  logic                             m_enable,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             m_ready,
  output logic                             m_error,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic [DATA_WIDTH/8-1:0]          s_wstrb,
  output logic                             s_write,
  output logic [NUM_SLAVES-1:0]            s_enable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  output logic [15:0]                      err_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // Counter must hold 0..TIMEOUT_CYCLES-1; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam int EW = ERR_COUNT_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    error_q;
  logic [EW-1:0]           err_q;

  logic                    hit;
  logic [SEL_W-1:0]        hit_idx;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    timeout_hit;

  logic                    latch_req;
  logic                    cnt_clr;
  logic                    cnt_inc;
  logic                    resp_load;
  logic                    resp_err;
  logic [DATA_WIDTH-1:0]   resp_data;

  // Address decode; scanning from the top down leaves the lowest matching
  // index in hit_idx, so lower slots win on overlapping windows.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Only the latched slave's ready/rdata are observed; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    resp_load = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    case (state_q)
      IDLE: begin
        if (m_enable) begin
          latch_req = 1'b1;
          if (hit) begin
            state_d = ACTIVE;
            cnt_clr = 1'b1;
          end else begin
            state_d   = RESP;
            resp_load = 1'b1;
            resp_err  = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // Ready is tested before timeout so a same-cycle answer is not an error.
        if (sel_ready) begin
          state_d   = RESP;
          resp_load = 1'b1;
          resp_data = s_write ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          state_d   = RESP;
          resp_load = 1'b1;
          resp_err  = 1'b1;
        end else begin
          cnt_inc = (TIMEOUT_CYCLES > 0);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      err_q   <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      s_write <= 1'b0;
    end else begin
      if (latch_req) begin
        sel_q   <= hit_idx;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
        s_write <= m_write;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (resp_load) begin
        rdata_q <= resp_data;
        error_q <= resp_err;
      end
      if ((state_q == RESP) && error_q && (err_q != {EW{1'b1}})) begin
        err_q <= err_q + EW'(1);
      end
    end
  end

  // Enable is a pure function of state and the latched index, so reset
  // removes it asynchronously.
  always_comb begin
    s_enable = '0;
    if (state_q == ACTIVE) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_q == SEL_W'(i)) begin
          s_enable[i] = 1'b1;
        end
      end
    end
  end

  assign m_ready   = (state_q == RESP);
  assign m_rdata   = rdata_q;
  assign m_error   = error_q;
  assign err_count = 16'(err_q);

endmodule

// File: tb/tb_bus_fabric.sv
// tb/tb_bus_fabric.sv - directed scoreboard bench for bus_fabric

module tb_bus_fabric;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  // Slot 3 sits inside slot 0's window to exercise lowest-index priority.
  localparam logic [NS*AW-1:0] BASE =
    {32'h0000_2000, 32'h4000_1000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hC000_0000};

  logic              clk;
  logic              rst;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic              m_write;
  logic              m_enable;
  logic [DW-1:0]     m_rdata;
  logic              m_ready;
  logic              m_error;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_wstrb;
  logic              s_write;
  logic [NS-1:0]     s_enable;
  logic [NS*DW-1:0]  s_rdata;
  logic [NS-1:0]     s_ready;
  logic [15:0]       err_count;

  bus_fabric #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .TIMEOUT_CYCLES(4), .ERR_COUNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_write(m_write), .m_enable(m_enable),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_write(s_write), .s_enable(s_enable),
    .s_rdata(s_rdata), .s_ready(s_ready), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: ready after wait_req enabled cycles, combinational on enable.
  logic [DW-1:0] slv_data [NS];
  int            wait_req [NS];
  int            wcnt     [NS];
  logic [NS-1:0] ready_on;
  logic [NS-1:0] stray_ready;

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) wcnt[i] <= s_enable[i] ? wcnt[i] + 1 : 0;
  end

  always_comb begin
    s_ready = '0;
    s_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      s_ready[i] = (s_enable[i] & ready_on[i] & (wcnt[i] >= wait_req[i])) | stray_ready[i];
      s_rdata[i*DW +: DW] = slv_data[i];
    end
  end

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: push expectation, drive request, watch enable/latched
  // fields each cycle, pop and compare on m_ready, then confirm pulse width.
  task automatic txn(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [DW/8-1:0] ws, input logic wr, input logic [NS-1:0] exp_en,
                     input int exp_en_cyc, input logic [DW-1:0] exp_rd, input logic exp_err);
    int   edges;
    int   en_cyc;
    logic done;
    exp_t e;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    m_addr = a; m_wdata = wd; m_wstrb = ws; m_write = wr; m_enable = 1'b1;
    edges = 0; en_cyc = 0; done = 1'b0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (s_enable != '0) begin
        en_cyc++;
        check({tag, "_sel"}, 96'(s_enable), 96'(exp_en));
        check({tag, "_fields"}, 96'({s_write, s_wstrb, s_addr, s_wdata}), 96'({wr, ws, a, wd}));
      end
      if (m_ready) begin
        done = 1'b1;
        e = sb.pop_front();
        check({tag, "_rdata"}, 96'(m_rdata), 96'(e.rdata));
        check({tag, "_error"}, 96'(m_error), 96'(e.err));
        check({tag, "_latency"}, 96'(edges), 96'(exp_en_cyc + 1));
        check({tag, "_en_cycles"}, 96'(en_cyc), 96'(exp_en_cyc));
        m_enable = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_no_ready observed=%0d cycles expected=completion", tag, edges);
      void'(sb.pop_back());
      m_enable = 1'b0;
    end
    @(negedge clk);
    check({tag, "_pulse"}, 96'(m_ready), 96'(0));
  endtask

  initial begin
    rst = 1'b1;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; m_write = 1'b0; m_enable = 1'b0;
    ready_on = 4'b1111; stray_ready = '0;
    slv_data[0] = 32'hDEADBEEF; slv_data[1] = 32'h11111111;
    slv_data[2] = 32'h22222222; slv_data[3] = 32'h33333333;
    for (int i = 0; i < NS; i++) wait_req[i] = 0;
    repeat (3) @(negedge clk);

    check("rst_s_enable", 96'(s_enable), 96'(0));
    check("rst_m_ready", 96'(m_ready), 96'(0));
    check("rst_m_resp", 96'({m_error, m_rdata}), 96'(0));
    check("rst_s_fields", 96'({s_write, s_wstrb, s_addr, s_wdata}), 96'(0));
    check("rst_err_count", 96'(err_count), 96'(0));
    rst = 1'b0;
    @(negedge clk);

    // Combinational-ready read of slave 0; slave 2 raises a stray ready.
    stray_ready = 4'b0100;
    txn("read_s0", 32'h0000_0010, 32'h0, 4'hF, 1'b0, 4'b0001, 1, 32'hDEADBEEF, 1'b0);
    stray_ready = '0;

    // Write with three wait cycles; write data never comes back as rdata.
    wait_req[2] = 3;
    txn("write_s2", 32'h4000_1004, 32'h12345678, 4'b0011, 1'b1, 4'b0100, 4, 32'h0, 1'b0);
    wait_req[2] = 0;

    txn("unmapped", 32'h8000_0000, 32'h0, 4'hF, 1'b0, 4'b0000, 0, 32'h0, 1'b1);
    check("unmapped_err_count", 96'(err_count), 96'(1));

    ready_on[1] = 1'b0;
    txn("timeout_s1", 32'h4000_0008, 32'h0, 4'hF, 1'b0, 4'b0010, 4, 32'h0, 1'b1);
    check("timeout_err_count", 96'(err_count), 96'(2));

    // Address in both slot 0 and slot 3 windows: slot 0 wins.
    txn("overlap", 32'h0000_2004, 32'h0, 4'hF, 1'b0, 4'b0001, 1, 32'hDEADBEEF, 1'b0);

    // Ready lands on the same cycle the timeout would fire.
    wait_req[0] = 3;
    slv_data[0] = 32'h0BADF00D;
    txn("ready_at_timeout", 32'h0000_0100, 32'h0, 4'hF, 1'b0, 4'b0001, 4, 32'h0BADF00D, 1'b0);
    check("ready_at_timeout_err_count", 96'(err_count), 96'(2));
    wait_req[0] = 0;

    // Reset while ACTIVE: enable must drop asynchronously.
    m_addr = 32'h4000_0000; m_wdata = '0; m_wstrb = 4'hF; m_write = 1'b0; m_enable = 1'b1;
    @(posedge clk); @(negedge clk);
    m_enable = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_active", 96'(s_enable), 96'(4'b0010));
    rst = 1'b1;
    #1;
    check("mid_rst_s_enable", 96'(s_enable), 96'(0));
    check("mid_rst_m_ready", 96'(m_ready), 96'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_err_count", 96'(err_count), 96'(0));
    check("post_rst_idle", 96'({m_ready, s_enable}), 96'(0));
    slv_data[0] = 32'hCAFEF00D;
    wait_req[0] = 1;
    txn("post_rst_read", 32'h0000_0040, 32'h0, 4'hF, 1'b0, 4'b0001, 2, 32'hCAFEF00D, 1'b0);
    wait_req[0] = 0;

    // Error counter (4 bits in this build) must stick at all-ones.
    for (int k = 0; k < 17; k++) begin
      txn("sat_timeout", 32'h4000_0010, 32'h0, 4'hF, 1'b0, 4'b0010, 4, 32'h0, 1'b1);
      if (k == 13) check("sat_err_count_14", 96'(err_count), 96'(14));
    end
    check("sat_err_count", 96'(err_count), 96'(15));
    check("sb_empty", 96'(sb.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
